// File: rtl/p09_vga_sync_tracker_if.sv
// p09_vga_sync_tracker_if
// Sync stream in, recovered raster timing out. The master side (a sync source
// or test driver) drives the active-low syncs and observes the recovered
// timing; the slave side is the tracker itself.
interface p09_vga_sync_tracker_if;
  logic       hsync_in;
  logic       vsync_in;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       active;
  logic       line_pulse;
  logic       frame_pulse;
  logic       locked;
  logic [7:0] err_count;

  modport master (
    output hsync_in, vsync_in,
    input  hpos, vpos, active, line_pulse, frame_pulse, locked, err_count
  );

  modport slave (
    input  hsync_in, vsync_in,
    output hpos, vpos, active, line_pulse, frame_pulse, locked, err_count
  );
endinterface

// File: rtl/p09_vga_sync_tracker.sv
// p09_vga_sync_tracker
// Recovers hpos/vpos/active/line_pulse/frame_pulse from an external active-low
// hsync/vsync stream using a flywheel counter. SEARCH waits for an hsync edge,
// ALIGN realigns on every mismatch until enough consecutive lines hit and a
// vsync edge has been seen, LOCKED free-runs and only tolerates a bounded
// number of consecutive hsync misses.
// Optional feature: define P09_VGA_TRACK_ERRCNT_EN to build the saturating
// sync error counter on err_count; otherwise err_count is tied to zero.
module p09_vga_sync_tracker #(
  parameter int H_TOTAL      = 800,
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int V_TOTAL      = 525,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 490,
  parameter int LOCK_LINES   = 4,
  parameter int MISS_LIMIT   = 3
) (
  input logic                   clk,
  input logic                   nRst,
  p09_vga_sync_tracker_if.slave trk
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SS      = 10'(H_SYNC_START);
  localparam logic [9:0] H_REALIGN = 10'(H_SYNC_START + 1);
  localparam logic [9:0] V_SS      = 10'(V_SYNC_START);
  localparam logic [9:0] V_SS_NEXT = 10'(V_SYNC_START + 1);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [3:0] LOCK_N    = 4'(LOCK_LINES);
  localparam logic [3:0] MISS_N    = 4'(MISS_LIMIT);

  state_e     state_q, state_d;
  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       vseen_q, vseen_d;
  logic [3:0] good_lines_q, good_lines_d;
  logic [3:0] miss_cnt_q, miss_cnt_d;
  logic       hs_q, vs_q;

  logic       hs_fall_s, vs_fall_s;
  logic       h_wrap_s, v_wrap_s;
  logic       check_pt_s, hit_s, miss_s, v_err_s;
  logic [9:0] hpos_inc_s, vpos_inc_s, vpos_reload_s;

  // Edge detection, flywheel increments and hit/miss classification
  always_comb begin
    hs_fall_s     = hs_q & ~trk.hsync_in;
    vs_fall_s     = vs_q & ~trk.vsync_in;
    h_wrap_s      = (hpos_q == H_LAST);
    v_wrap_s      = (vpos_q == V_LAST);
    check_pt_s    = (hpos_q == H_SS);
    hit_s         = check_pt_s & hs_fall_s;
    // a missing edge at the check point and a stray edge elsewhere are both misses
    miss_s        = check_pt_s ^ hs_fall_s;
    v_err_s       = (state_q == ST_LOCKED) & vs_fall_s & (vpos_q != V_SS);
    hpos_inc_s    = h_wrap_s ? 10'd0 : (hpos_q + 10'd1);
    if (h_wrap_s) begin
      vpos_inc_s = v_wrap_s ? 10'd0 : (vpos_q + 10'd1);
    end else begin
      vpos_inc_s = vpos_q;
    end
    // a vsync edge on the last pixel of a line already belongs to the next line
    vpos_reload_s = h_wrap_s ? V_SS_NEXT : V_SS;
  end

  // Tracker state machine: next state, counters and lock bookkeeping
  always_comb begin
    state_d      = state_q;
    hpos_d       = hpos_q;
    vpos_d       = vpos_q;
    vseen_d      = vseen_q;
    good_lines_d = good_lines_q;
    miss_cnt_d   = miss_cnt_q;
    case (state_q)
      ST_SEARCH: begin
        hpos_d       = 10'd0;
        vpos_d       = 10'd0;
        vseen_d      = 1'b0;
        good_lines_d = 4'd0;
        miss_cnt_d   = 4'd0;
        if (hs_fall_s) begin
          hpos_d  = H_REALIGN;
          state_d = ST_ALIGN;
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_ALIGN: begin
        hpos_d     = hpos_inc_s;
        vpos_d     = vpos_inc_s;
        miss_cnt_d = 4'd0;
        if (hit_s) begin
          good_lines_d = (good_lines_q == 4'hF) ? good_lines_q : (good_lines_q + 4'd1);
        end else if (miss_s) begin
          good_lines_d = 4'd0;
          if (hs_fall_s) begin
            hpos_d = H_REALIGN;
          end else begin
            hpos_d = hpos_inc_s;
          end
        end else begin
          good_lines_d = good_lines_q;
        end
        if (vs_fall_s) begin
          vpos_d  = vpos_reload_s;
          vseen_d = 1'b1;
        end else begin
          vseen_d = vseen_q;
        end
        if ((good_lines_d >= LOCK_N) && vseen_d) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_ALIGN;
        end
      end
      ST_LOCKED: begin
        hpos_d = hpos_inc_s;
        vpos_d = vpos_inc_s;
        if (hit_s) begin
          miss_cnt_d = 4'd0;
        end else if (miss_s) begin
          miss_cnt_d = (miss_cnt_q == 4'hF) ? miss_cnt_q : (miss_cnt_q + 4'd1);
        end else begin
          miss_cnt_d = miss_cnt_q;
        end
        if (v_err_s) begin
          vpos_d = vpos_reload_s;
        end else begin
          vpos_d = vpos_inc_s;
        end
        if (miss_cnt_d >= MISS_N) begin
          state_d      = ST_SEARCH;
          hpos_d       = 10'd0;
          vpos_d       = 10'd0;
          vseen_d      = 1'b0;
          good_lines_d = 4'd0;
          miss_cnt_d   = 4'd0;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d      = ST_SEARCH;
        hpos_d       = 10'd0;
        vpos_d       = 10'd0;
        vseen_d      = 1'b0;
        good_lines_d = 4'd0;
        miss_cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter and sync-history registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q      <= ST_SEARCH;
      hpos_q       <= 10'd0;
      vpos_q       <= 10'd0;
      vseen_q      <= 1'b0;
      good_lines_q <= 4'd0;
      miss_cnt_q   <= 4'd0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      hpos_q       <= hpos_d;
      vpos_q       <= vpos_d;
      vseen_q      <= vseen_d;
      good_lines_q <= good_lines_d;
      miss_cnt_q   <= miss_cnt_d;
      hs_q         <= trk.hsync_in;
      vs_q         <= trk.vsync_in;
    end
  end

`ifdef P09_VGA_TRACK_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;
  logic       err_evt_s;

  // One error per cycle for any hsync miss while tracking or vsync mismatch while locked
  always_comb begin
    err_evt_s   = ((state_q != ST_SEARCH) & miss_s) | v_err_s;
    err_count_d = err_count_q;
    if (err_evt_s && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Error counter register, cleared only by reset
  always_ff @(posedge clk) begin
    if (!nRst) begin
      err_count_q <= 8'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign trk.err_count = err_count_q;
`else
  assign trk.err_count = 8'd0;
`endif

  assign trk.hpos        = hpos_q;
  assign trk.vpos        = vpos_q;
  assign trk.locked      = (state_q == ST_LOCKED);
  assign trk.active      = (state_q == ST_LOCKED) & (hpos_q < H_ACT) & (vpos_q < V_ACT);
  assign trk.line_pulse  = (state_q != ST_SEARCH) & (hpos_q == H_LAST);
  assign trk.frame_pulse = trk.line_pulse & (vpos_q == V_LAST) & vseen_q;

endmodule

// File: doc/p09_vga_sync_tracker.md
Name: p09_vga_sync_tracker

Overview:
- Receive-side counterpart of the breakout VGA timing generator. Takes active-low hsync/vsync in the pixel-clock domain and recovers hpos/vpos/active/line_pulse/frame_pulse with a flywheel counter.
- Locks after consistent sync is seen and holds through isolated glitches or missing pulses.
- Used by self-test and overlay logic that must align to an external 640x480 sync stream.

Parameters:
- H_TOTAL, 800, clocks per line
- H_ACTIVE, 640, active clocks per line
- H_SYNC_START, 656, hpos value in the first cycle hsync_in is sampled low
- V_TOTAL, 525, lines per frame
- V_ACTIVE, 480, active lines
- V_SYNC_START, 490, vpos value in the first cycle vsync_in is sampled low
- LOCK_LINES, 4, consecutive hsync hits required to lock (1..15)
- MISS_LIMIT, 3, consecutive hsync misses that drop lock (1..15)

Ports:
- clk  in  1  pixel clock
- nRst  in  1  reset. Synchronous, active-low.
- hsync_in  in  1  active-low horizontal sync, synchronous to clk
- vsync_in  in  1  active-low vertical sync, synchronous to clk
- hpos  out  10  recovered horizontal position
- vpos  out  10  recovered vertical position
- active  out  1  locked && hpos<H_ACTIVE && vpos<V_ACTIVE
- line_pulse  out  1  (state!=SEARCH) && hpos==H_TOTAL-1
- frame_pulse  out  1  line_pulse && vpos==V_TOTAL-1 && vseen
- locked  out  1  state==LOCKED
- err_count  out  8  saturating sync error count (see Optional Feature)

Behaviour:
- Reset (nRst low at a clk edge):
  - state=SEARCH, hpos=0, vpos=0, vseen=0, good_lines=0, miss_cnt=0, err_count=0.
  - hs_q=1, vs_q=1.
  - All outputs therefore 0.
- Reset mid-operation aborts immediately; there is no drain.
- Edge detect:
  - hs_fall = hs_q && !hsync_in.
  - vs_fall = vs_q && !vsync_in.
  - hs_q/vs_q register the inputs every cycle.
  - Detection is zero-latency: it applies in the same cycle the low level is first sampled.
- Flywheel, when state!=SEARCH:
  - hpos increments and wraps H_TOTAL-1 -> 0.
  - vpos increments on the wrap and wraps V_TOTAL-1 -> 0.
- Check point: the cycle with hpos==H_SYNC_START.
  - hit = check point && hs_fall.
  - miss = check point without hs_fall, or hs_fall at any other hpos. A stray edge plus a missing check-point edge in the same line counts as 2 misses.
- SEARCH:
  - Counters held at 0.
  - On hs_fall: hpos := H_SYNC_START+1, good_lines=0, go to ALIGN.
- ALIGN:
  - hit: good_lines++ (saturating).
  - miss: good_lines=0. If hs_fall is present, hpos := H_SYNC_START+1 (realign).
  - vs_fall: vpos := V_SYNC_START+1 if the same cycle is the hpos wrap, else V_SYNC_START; set vseen=1.
  - Go to LOCKED on the clock after good_lines>=LOCK_LINES && vseen.
- LOCKED:
  - hit: miss_cnt=0.
  - miss: miss_cnt++. No realign (flywheel keeps running).
  - miss_cnt reaching MISS_LIMIT: next state SEARCH, counters and vseen cleared.
  - vs_fall with vpos==V_SYNC_START: no action.
  - vs_fall with any other vpos: reload vpos as in ALIGN and count an error. Stays locked.
- Simultaneous events:
  - vs_fall reload takes priority over the vpos increment.
  - hs_fall realign takes priority over the hpos increment.
- Width rules:
  - Counters are 10-bit; V_TOTAL must be <= 1024.
  - good_lines and miss_cnt are 4-bit.

Optional Feature:
- Macro P09_VGA_TRACK_ERRCNT_EN.
- Defined: err_count increments by 1 (saturating at 255) per cycle with a miss in ALIGN/LOCKED or a vpos-mismatch vs_fall in LOCKED. If both occur in one cycle, it increments by 1. Cleared only by reset.
- Undefined: err_count tied to 0 and its counter logic is omitted.

Test Plan:
- Clean 800x525 stream, hsync low at gen-hpos 656..751, vsync low lines 490..491 -> hits every line; locked=1 one cycle after the first vs_fall; tracker hpos/vpos equal generator positions thereafter; err_count=0.
- Locked, then 640*480=307200 active cycles per frame -> frame_pulse exactly once per 420000 cycles, at hpos=799/vpos=524.
- Locked, then drop 2 consecutive hsync pulses, then resume -> locked stays 1; miss_cnt returns to 0; err_count=2 (macro on); hpos continuity preserved.
- Locked, then drop 3 consecutive hsync pulses -> locked=0 and hpos=0 on the cycle after the third check point; relock after 4 hits plus vsync.
- Locked, then inject a vsync falling edge at vpos=100 -> vpos=490 next cycle; locked stays 1; err_count +1 (macro on; 0 with macro off).
- Assert nRst low for one cycle mid-frame while locked -> all outputs 0 on the next edge; state SEARCH; relock from the next hs_fall.
